tile_map_ram: RTL and testbench

//  Parametrised, run-time writable tile/character map for the VGA text/tile layer.

---
 rtl/tile_map_ram.sv | 160 ++++++++++++++++
 tb/tb_tile_map_ram.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_ram.sv
`default_nettype none
// ============================================================================
// Module   : tile_map_ram
// Purpose  : Run-time writable ROWS x COLS tile-code map with a 1-cycle read
//            port, a single-cell write port and a whole-map fill engine.
//            Define TILE_MAP_SCROLL_EN to add a horizontal read scroll offset.
// Revision : 1.0  initial release
// ============================================================================
module tile_map_ram #(
    parameter int                COLS      = 16,
    parameter int                ROWS      = 16,
    parameter int                CODE_W    = 7,
    parameter logic [CODE_W-1:0] INIT_CODE = '0,
    parameter int                COL_W     = $clog2(COLS),
    parameter int                ROW_W     = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COL_W-1:0]  rd_col,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [CODE_W-1:0] rd_code,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [CODE_W-1:0] wr_code,
    output logic              wr_ack,
    input  logic              fill_start,
    input  logic [CODE_W-1:0] fill_code,
    output logic              busy,
`ifdef TILE_MAP_SCROLL_EN
    input  logic [COL_W-1:0]  scroll_col,
`endif
    output logic              fill_done
);

    localparam int DEPTH = COLS * ROWS;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [COL_W:0]   c_cols_x = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0]   c_rows_x = (ROW_W + 1)'(ROWS);
    localparam logic [IDX_W-1:0] c_cols   = IDX_W'(COLS);
    localparam logic [IDX_W-1:0] c_last   = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic [CODE_W-1:0] r_fill_val, w_fill_val_nxt;
    logic              w_ack_nxt, w_done_nxt;

    logic [CODE_W-1:0] r_mem [DEPTH];

    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [CODE_W-1:0] w_wdata;

    logic              w_rd_hit, w_wr_hit;
    logic [COL_W-1:0]  w_eff_col;
    logic [IDX_W-1:0]  w_rd_idx, w_wr_idx;

    // Range checks use one extra bit so a power-of-two COLS/ROWS compares correctly.
    assign w_rd_hit = ({1'b0, rd_col} < c_cols_x) && ({1'b0, rd_row} < c_rows_x);
    assign w_wr_hit = ({1'b0, wr_col} < c_cols_x) && ({1'b0, wr_row} < c_rows_x);

`ifdef TILE_MAP_SCROLL_EN
    logic [COL_W:0] w_scroll_mod, w_col_sum;

    // scroll_col < 2*COLS and rd_col < COLS when in range, so one subtract suffices each.
    always_comb begin
        w_scroll_mod = {1'b0, scroll_col};
        if (w_scroll_mod >= c_cols_x) begin
            w_scroll_mod = w_scroll_mod - c_cols_x;
        end
        w_col_sum = {1'b0, rd_col} + w_scroll_mod;
        if (w_col_sum >= c_cols_x) begin
            w_col_sum = w_col_sum - c_cols_x;
        end
    end
    assign w_eff_col = w_col_sum[COL_W-1:0];
`else
    assign w_eff_col = rd_col;
`endif

    assign w_rd_idx = w_rd_hit ? (IDX_W'(rd_row) * c_cols + IDX_W'(w_eff_col)) : '0;
    assign w_wr_idx = w_wr_hit ? (IDX_W'(wr_row) * c_cols + IDX_W'(wr_col))    : '0;

    assign busy = (r_state == S_FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FILL;
            r_ptr      <= '0;
            r_fill_val <= INIT_CODE;
            wr_ack     <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_fill_val <= w_fill_val_nxt;
            wr_ack     <= w_ack_nxt;
            fill_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_fill_val_nxt = r_fill_val;
        w_ack_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        w_we           = 1'b0;
        w_waddr        = w_wr_idx;
        w_wdata        = wr_code;
        case (r_state)
            S_FILL: begin
                w_we    = 1'b1;
                w_waddr = r_ptr;
                w_wdata = r_fill_val;
                if (r_ptr == c_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            S_IDLE: begin
                // A fill request takes priority over a same-cycle cell write.
                if (fill_start) begin
                    w_state_nxt    = S_FILL;
                    w_ptr_nxt      = '0;
                    w_fill_val_nxt = fill_code;
                end else if (wr_en && w_wr_hit) begin
                    w_we      = 1'b1;
                    w_ack_nxt = 1'b1;
                end
            end
        endcase
    end

    // Storage is never cleared by rst; the post-reset auto-fill initialises it.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Non-blocking read against the same-edge write gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_code <= '0;
        end else begin
            rd_code <= w_rd_hit ? r_mem[w_rd_idx] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_map_ram.sv
`default_nettype none
// Testbench for tile_map_ram: a 16x16 map (INIT 7'h61) and a 10x16 map.
module tb_tile_map_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16 x 16 instance
    logic       a_rst, a_wr_en, a_fill_start, a_wr_ack, a_busy, a_fill_done;
    logic [3:0] a_rd_col, a_rd_row, a_wr_col, a_wr_row, a_scroll;
    logic [6:0] a_rd_code, a_wr_code, a_fill_code;

    // 10 x 16 instance
    logic       b_rst, b_wr_en, b_fill_start, b_wr_ack, b_busy, b_fill_done;
    logic [3:0] b_rd_col, b_rd_row, b_wr_col, b_wr_row, b_scroll;
    logic [6:0] b_rd_code, b_wr_code, b_fill_code;

    tile_map_ram #(.COLS(16), .ROWS(16), .CODE_W(7), .INIT_CODE(7'h61)) u_a (
        .clk        (clk),
        .rst        (a_rst),
        .rd_col     (a_rd_col),
        .rd_row     (a_rd_row),
        .rd_code    (a_rd_code),
        .wr_en      (a_wr_en),
        .wr_col     (a_wr_col),
        .wr_row     (a_wr_row),
        .wr_code    (a_wr_code),
        .wr_ack     (a_wr_ack),
        .fill_start (a_fill_start),
        .fill_code  (a_fill_code),
        .busy       (a_busy),
`ifdef TILE_MAP_SCROLL_EN
        .scroll_col (a_scroll),
`endif
        .fill_done  (a_fill_done)
    );

    tile_map_ram #(.COLS(10), .ROWS(16), .CODE_W(7), .INIT_CODE(7'h61)) u_b (
        .clk        (clk),
        .rst        (b_rst),
        .rd_col     (b_rd_col),
        .rd_row     (b_rd_row),
        .rd_code    (b_rd_code),
        .wr_en      (b_wr_en),
        .wr_col     (b_wr_col),
        .wr_row     (b_wr_row),
        .wr_code    (b_wr_code),
        .wr_ack     (b_wr_ack),
        .fill_start (b_fill_start),
        .fill_code  (b_fill_code),
        .busy       (b_busy),
`ifdef TILE_MAP_SCROLL_EN
        .scroll_col (b_scroll),
`endif
        .fill_done  (b_fill_done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic [3:0] wrow, wcol;
        logic [6:0] wcode;
        logic [3:0] rrow, rcol;
        logic [6:0] exp_rd;
        logic       exp_ack;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads every cell of the 16x16 map and reports the mismatch count.
    task automatic read_all_a(input string name, input logic [6:0] exp);
        int bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                a_rd_row = 4'(r);
                a_rd_col = 4'(c);
                tick();
                if (a_rd_code !== exp) bad++;
            end
        end
        check(name, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;

        vecs[0] = '{1'b1, 4'd3,  4'd5,  7'h6B, 4'd3,  4'd5,  7'h61, 1'b1};
        vecs[1] = '{1'b0, 4'd3,  4'd5,  7'h6B, 4'd3,  4'd5,  7'h6B, 1'b0};
        vecs[2] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd3,  4'd6,  7'h61, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  4'd0,  7'h72, 4'd0,  4'd0,  7'h61, 1'b1};
        vecs[4] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd0,  4'd0,  7'h72, 1'b0};
        vecs[5] = '{1'b1, 4'd15, 4'd15, 7'h55, 4'd15, 4'd15, 7'h61, 1'b1};
        vecs[6] = '{1'b0, 4'd15, 4'd15, 7'h11, 4'd15, 4'd15, 7'h55, 1'b0};
        vecs[7] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd3,  4'd4,  7'h61, 1'b0};

        a_rst = 1'b1; a_wr_en = 1'b0; a_fill_start = 1'b0; a_scroll = '0;
        a_rd_col = '0; a_rd_row = '0; a_wr_col = '0; a_wr_row = '0;
        a_wr_code = '0; a_fill_code = '0;
        b_rst = 1'b1; b_wr_en = 1'b0; b_fill_start = 1'b0; b_scroll = '0;
        b_rd_col = '0; b_rd_row = '0; b_wr_col = '0; b_wr_row = '0;
        b_wr_code = '0; b_fill_code = '0;

        // Reset and automatic INIT_CODE fill
        tick();
        tick();
        check("reset rd_code", a_rd_code, 0);
        check("reset wr_ack", a_wr_ack, 0);
        check("reset fill_done", a_fill_done, 0);
        check("reset busy", a_busy, 1);
        a_rst = 1'b0;
        n = 0; seen = 0;
        while (a_busy && n < 1000) begin
            if (a_fill_done) seen = 1;
            n++;
            tick();
        end
        check("init busy cycles", n, 256);
        check("init early fill_done", seen, 0);
        check("init fill_done pulse", a_fill_done, 1);
        tick();
        check("init fill_done clears", a_fill_done, 0);
        read_all_a("init contents", 7'h61);

        // Table-driven writes and reads, including read-first collisions
        for (int i = 0; i < 8; i++) begin
            a_wr_en   = vecs[i].we;
            a_wr_row  = vecs[i].wrow;
            a_wr_col  = vecs[i].wcol;
            a_wr_code = vecs[i].wcode;
            a_rd_row  = vecs[i].rrow;
            a_rd_col  = vecs[i].rcol;
            tick();
            check($sformatf("vec%0d rd_code", i), a_rd_code, vecs[i].exp_rd);
            check($sformatf("vec%0d wr_ack", i), a_wr_ack, vecs[i].exp_ack);
        end
        a_wr_en = 1'b0;

        // Fill with simultaneous write; mid-fill requests ignored
        a_fill_code = 7'h01; a_fill_start = 1'b1;
        a_wr_en = 1'b1; a_wr_row = 4'd1; a_wr_col = 4'd1; a_wr_code = 7'h7F;
        tick();
        a_fill_start = 1'b0; a_wr_en = 1'b0;
        check("fill+wr no ack", a_wr_ack, 0);
        check("fill busy", a_busy, 1);
        n = 0; seen = 0;
        while (a_busy && n < 1000) begin
            n++;
            if (n == 50) begin
                a_wr_en = 1'b1; a_fill_start = 1'b1; a_fill_code = 7'h33;
            end else begin
                a_wr_en = 1'b0; a_fill_start = 1'b0;
            end
            tick();
            if (a_wr_ack) seen = 1;
        end
        a_wr_en = 1'b0; a_fill_start = 1'b0;
        check("fill busy cycles", n, 256);
        check("fill ack while busy", seen, 0);
        check("fill fill_done pulse", a_fill_done, 1);
        read_all_a("fill contents", 7'h01);

`ifdef TILE_MAP_SCROLL_EN
        a_wr_en = 1'b1; a_wr_row = 4'd2; a_wr_col = 4'd1; a_wr_code = 7'h2A;
        tick();
        a_wr_en = 1'b0;
        a_scroll = 4'd3; a_rd_row = 4'd2; a_rd_col = 4'd14;
        tick();
        check("scroll wrap read", a_rd_code, 7'h2A);
        a_scroll = 4'd0;
`endif

        // 10-column map: aborted fill, restart, range handling
        tick();
        b_rst = 1'b0;
        seen = 0;
        repeat (100) begin
            tick();
            if (b_fill_done) seen = 1;
        end
        b_rst = 1'b1;
        tick();
        if (b_fill_done) seen = 1;
        tick();
        if (b_fill_done) seen = 1;
        check("abort busy in reset", b_busy, 1);
        b_rst = 1'b0;
        n = 0;
        while (b_busy && n < 1000) begin
            if (b_fill_done) seen = 1;
            n++;
            tick();
        end
        check("abort no fill_done", seen, 0);
        check("refill busy cycles", n, 160);
        check("refill fill_done", b_fill_done, 1);

        b_wr_en = 1'b1; b_wr_row = 4'd2; b_wr_col = 4'd12; b_wr_code = 7'h44;
        tick();
        check("oob write no ack", b_wr_ack, 0);
        b_wr_col = 4'd9;
        tick();
        check("col9 write ack", b_wr_ack, 1);
        b_wr_en = 1'b0;
        b_rd_row = 4'd2; b_rd_col = 4'd12;
        tick();
        check("oob read zero", b_rd_code, 0);
        b_rd_col = 4'd9;
        tick();
        check("col9 read", b_rd_code, 7'h44);
        b_rd_row = 4'd3; b_rd_col = 4'd2;
        tick();
        check("oob write no alias", b_rd_code, 7'h61);
        b_rd_row = 4'd15; b_rd_col = 4'd9;
        tick();
        check("last cell refilled", b_rd_code, 7'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
